// File: rtl/conv_channel_accumulator.sv
// Channel accumulator: sums NUM_CHANNELS signed partial sums onto a bias, then applies
// ReLU, an arithmetic right shift and unsigned saturation, and emits over valid/ready.
module conv_channel_accumulator #(
  parameter int IN_WIDTH     = 20,
  parameter int ACC_WIDTH    = 24,
  parameter int NUM_CHANNELS = 3,
  parameter int OUT_WIDTH    = 8,
  parameter int SHIFT        = 8
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_enable,
  input  logic signed [ACC_WIDTH-1:0] i_bias,
  input  logic                        i_in_valid,
  output logic                        o_in_ready,
  input  logic signed [IN_WIDTH-1:0]  i_in_num,
  output logic                        o_out_valid,
  input  logic                        i_out_ready,
  output logic [OUT_WIDTH-1:0]        o_out_num,
  output logic                        o_sat_flag
);

  localparam int CNT_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_CHANNELS - 1);
  localparam logic signed [ACC_WIDTH-1:0] MAX_Q = ACC_WIDTH'((2 ** OUT_WIDTH) - 1);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_EMIT} state_t;

  state_t                      r_state;
  state_t                      w_state_next;
  logic signed [ACC_WIDTH-1:0] r_acc_p0;
  logic signed [ACC_WIDTH-1:0] w_acc_next;
  logic signed [ACC_WIDTH-1:0] w_in_ext;
  logic [CNT_W-1:0]            r_cnt_p0;
  logic [OUT_WIDTH-1:0]        r_out_num_p1;
  logic                        r_sat_p1;
  logic                        w_beat;
  logic                        w_last;
  logic [OUT_WIDTH:0]          w_act;

  // Returns {clipped, activation}: ReLU, truncating shift, clamp to the unsigned range.
  function automatic logic [OUT_WIDTH:0] relu_shift_sat(input logic signed [ACC_WIDTH-1:0] s);
    logic signed [ACC_WIDTH-1:0] q;
    q = s >>> SHIFT;
    if (s[ACC_WIDTH-1])
      return '0;
    else if (q > MAX_Q)
      return {1'b1, {OUT_WIDTH{1'b1}}};
    else
      return {1'b0, q[OUT_WIDTH-1:0]};
  endfunction

  assign w_in_ext   = {{(ACC_WIDTH-IN_WIDTH){i_in_num[IN_WIDTH-1]}}, i_in_num};
  assign w_acc_next = ((r_cnt_p0 == '0) ? i_bias : r_acc_p0) + w_in_ext;
  assign w_last     = (r_cnt_p0 == LAST_CNT);
  assign w_act      = relu_shift_sat(w_acc_next);

  always_comb begin
    w_state_next = r_state;
    o_in_ready   = 1'b0;
    w_beat       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (i_enable) w_state_next = S_ACCUM;
      end
      S_ACCUM: begin
        o_in_ready = i_enable;
        w_beat     = i_enable & i_in_valid;
        if (w_beat && w_last) w_state_next = S_EMIT;
      end
      S_EMIT: begin
        if (i_enable && i_out_ready) w_state_next = S_ACCUM;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign o_out_valid = (r_state == S_EMIT);
  assign o_out_num   = r_out_num_p1;
  assign o_sat_flag  = r_sat_p1;

  // p0: accumulator and beat counter; p1: output register loaded on the last beat
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_acc_p0     <= '0;
      r_cnt_p0     <= '0;
      r_out_num_p1 <= '0;
      r_sat_p1     <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_beat) begin
        r_acc_p0 <= w_acc_next;
        r_cnt_p0 <= w_last ? '0 : r_cnt_p0 + 1'b1;
        if (w_last) begin
          r_out_num_p1 <= w_act[OUT_WIDTH-1:0];
          if (w_act[OUT_WIDTH]) r_sat_p1 <= 1'b1;
        end
      end
    end
  end

endmodule
